// File: rtl/negative_threshold_zone_tracker_pkg.sv
// ============================================================================
// Module : negative_threshold_zone_tracker_pkg
// Brief  : Zone type, zone codes and comparator-flag decode shared by the tracker.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package negative_threshold_zone_tracker_pkg;

  typedef logic [1:0] zone_t;

  localparam zone_t ZONE_LOW     = 2'd0;
  localparam zone_t ZONE_MID     = 2'd1;
  localparam zone_t ZONE_HIGH    = 2'd2;
  localparam zone_t ZONE_UNKNOWN = 2'd3;

  typedef struct packed {
    zone_t zone;
    logic  illegal;
  } zone_decode_t;

  // neg50 set without neg100 is physically impossible for a sane comparator pair
  function automatic zone_decode_t decode_flags(input logic over_neg100, input logic over_neg50);
    zone_decode_t d;
    d.illegal = over_neg50 & ~over_neg100;
    case ({over_neg100, over_neg50})
      2'b00:   d.zone = ZONE_LOW;
      2'b10:   d.zone = ZONE_MID;
      2'b11:   d.zone = ZONE_HIGH;
      default: d.zone = ZONE_UNKNOWN;
    endcase
    return d;
  endfunction

endpackage

`default_nettype wire

// File: rtl/negative_threshold_zone_tracker_if.sv
// ============================================================================
// Module : negative_threshold_zone_tracker_if
// Brief  : Comparator-flag input and zone/event output bundle of the tracker.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface negative_threshold_zone_tracker_if #(
  parameter int CNT_W = 16
);
  import negative_threshold_zone_tracker_pkg::*;

  logic             sample_valid;
  logic             data_over_neg100;
  logic             data_over_neg50;
  zone_t            zone;
  logic             evt_valid;
  logic             evt_ready;
  zone_t            evt_from;
  zone_t            evt_to;
  logic [CNT_W-1:0] transition_count;
  logic             err_illegal;
  logic             evt_overflow;

  modport master (
    output sample_valid, data_over_neg100, data_over_neg50, evt_ready,
    input  zone, evt_valid, evt_from, evt_to, transition_count, err_illegal, evt_overflow
  );

  modport slave (
    input  sample_valid, data_over_neg100, data_over_neg50, evt_ready,
    output zone, evt_valid, evt_from, evt_to, transition_count, err_illegal, evt_overflow
  );

endinterface

`default_nettype wire

// File: rtl/negative_threshold_zone_tracker_event_reg.sv
// ============================================================================
// Module : zone_event_reg
// Brief  : One-deep valid/ready holding register for zone-change events.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module zone_event_reg
  import negative_threshold_zone_tracker_pkg::*;
(
  input  wire   clk,
  input  wire   rst_n,
  input  wire   i_load,
  input  zone_t i_from,
  input  zone_t i_to,
  input  wire   i_ready,
  output logic  o_valid,
  output zone_t o_from,
  output zone_t o_to,
  output logic  o_overflow
);

  logic  r_valid;
  zone_t r_from;
  zone_t r_to;
  logic  r_overflow;
  logic  w_accept;

  assign w_accept = r_valid & i_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_valid    <= 1'b0;
      r_from     <= ZONE_LOW;
      r_to       <= ZONE_LOW;
      r_overflow <= 1'b0;
    end else if (i_load) begin
      // a slot freed by this cycle's accept can take the new event directly
      if (!r_valid || w_accept) begin
        r_valid <= 1'b1;
        r_from  <= i_from;
        r_to    <= i_to;
      end else begin
        r_overflow <= 1'b1;
      end
    end else if (w_accept) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid    = r_valid;
  assign o_from     = r_from;
  assign o_to       = r_to;
  assign o_overflow = r_overflow;

endmodule

`default_nettype wire

// File: rtl/negative_threshold_zone_tracker.sv
// ============================================================================
// Module : negative_threshold_zone_tracker
// Brief  : Debounced LOW/MID/HIGH zone tracker with event output and counters.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module negative_threshold_zone_tracker
  import negative_threshold_zone_tracker_pkg::*;
#(
  parameter int DEBOUNCE = 4,
  parameter int CNT_W    = 16
) (
  input  wire clk,
  input  wire rst_n,
  negative_threshold_zone_tracker_if.slave bus
);

  localparam logic [7:0]       c_debounce = 8'(DEBOUNCE);
  localparam logic [CNT_W-1:0] c_cnt_max  = '1;

  zone_t            r_zone;
  zone_t            r_cand;
  logic [7:0]       r_run;
  logic [CNT_W-1:0] r_count;
  logic             r_err;

  zone_decode_t     w_dec;
  zone_t            w_cand_next;
  logic [7:0]       w_run_next;
  logic             w_commit;

  always_comb begin
    w_dec       = decode_flags(bus.data_over_neg100, bus.data_over_neg50);
    w_cand_next = r_cand;
    w_run_next  = r_run;
    w_commit    = 1'b0;
    if (bus.sample_valid) begin
      if (w_dec.illegal) begin
        w_cand_next = ZONE_UNKNOWN;
        w_run_next  = 8'd0;
      end else if (w_dec.zone == r_zone) begin
        w_cand_next = r_zone;
        w_run_next  = 8'd0;
      end else begin
        if (w_dec.zone == r_cand) begin
          w_run_next = r_run + 8'd1;
        end else begin
          w_cand_next = w_dec.zone;
          w_run_next  = 8'd1;
        end
        if (w_run_next == c_debounce) begin
          w_commit   = 1'b1;
          w_run_next = 8'd0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_zone  <= ZONE_UNKNOWN;
      r_cand  <= ZONE_UNKNOWN;
      r_run   <= 8'd0;
      r_count <= '0;
      r_err   <= 1'b0;
    end else begin
      r_cand <= w_cand_next;
      r_run  <= w_run_next;
      if (bus.sample_valid && w_dec.illegal) begin
        r_err <= 1'b1;
      end
      if (w_commit) begin
        r_zone <= w_dec.zone;
        // the initial lock-in from UNKNOWN is not a transition
        if (r_zone != ZONE_UNKNOWN && r_count != c_cnt_max) begin
          r_count <= r_count + 1'b1;
        end
      end
    end
  end

  zone_event_reg u_event_reg (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (w_commit),
    .i_from     (r_zone),
    .i_to       (w_dec.zone),
    .i_ready    (bus.evt_ready),
    .o_valid    (bus.evt_valid),
    .o_from     (bus.evt_from),
    .o_to       (bus.evt_to),
    .o_overflow (bus.evt_overflow)
  );

  assign bus.zone             = r_zone;
  assign bus.transition_count = r_count;
  assign bus.err_illegal      = r_err;

endmodule

`default_nettype wire

// File: tb/tb_negative_threshold_zone_tracker.sv
// ============================================================================
// Module : tb_negative_threshold_zone_tracker
// Brief  : Directed plus randomized bench for the zone tracker (CNT_W 16 and 2).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_negative_threshold_zone_tracker;

  localparam int DEBOUNCE = 4;

  logic clk = 1'b0;
  logic rst_n;
  logic sv, f100, f50, rdy;

  int checks   = 0;
  int failures = 0;

  // behavioural reference state
  int m_zone, m_cand, m_run, m_cnt;
  bit m_ev, m_err, m_ovf;
  int m_from, m_to;

  always #5 clk = ~clk;

  negative_threshold_zone_tracker_if #(.CNT_W(16)) bus16 ();
  negative_threshold_zone_tracker_if #(.CNT_W(2))  bus2 ();

  assign bus16.sample_valid     = sv;
  assign bus16.data_over_neg100 = f100;
  assign bus16.data_over_neg50  = f50;
  assign bus16.evt_ready        = rdy;
  assign bus2.sample_valid      = sv;
  assign bus2.data_over_neg100  = f100;
  assign bus2.data_over_neg50   = f50;
  assign bus2.evt_ready         = rdy;

  negative_threshold_zone_tracker #(.DEBOUNCE(DEBOUNCE), .CNT_W(16)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus16)
  );

  negative_threshold_zone_tracker #(.DEBOUNCE(DEBOUNCE), .CNT_W(2)) u_dut_sat (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus2)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int zone_of(input bit a, input bit b);
    if (!a && !b) return 0;
    if (a && !b)  return 1;
    return 2;
  endfunction

  task automatic model_reset();
    m_zone = 3; m_cand = 3; m_run = 0; m_cnt = 0;
    m_ev = 0; m_from = 0; m_to = 0; m_err = 0; m_ovf = 0;
  endtask

  // one clock of the reference: classify, debounce, then settle the event slot
  task automatic model_step();
    bit commit = 0;
    bit accept = m_ev && rdy;
    int s, old;
    if (!rst_n) begin
      model_reset();
      return;
    end
    if (sv) begin
      if (!f100 && f50) begin
        m_err = 1; m_run = 0; m_cand = 3;
      end else begin
        s = zone_of(f100, f50);
        if (s == m_zone) begin
          m_run = 0; m_cand = m_zone;
        end else begin
          m_run  = (s == m_cand) ? m_run + 1 : 1;
          m_cand = s;
          if (m_run == DEBOUNCE) begin
            commit = 1; old = m_zone; m_zone = s; m_run = 0;
            if (old != 3) m_cnt++;
          end
        end
      end
    end
    if (commit) begin
      if (!m_ev || accept) begin
        m_ev = 1; m_from = old; m_to = s;
      end else begin
        m_ovf = 1;
      end
    end else if (accept) begin
      m_ev = 0;
    end
  endtask

  task automatic check_all();
    chk("zone",      int'(bus16.zone),         m_zone);
    chk("evt_valid", int'(bus16.evt_valid),    int'(m_ev));
    chk("evt_from",  int'(bus16.evt_from),     m_from);
    chk("evt_to",    int'(bus16.evt_to),       m_to);
    chk("err",       int'(bus16.err_illegal),  int'(m_err));
    chk("ovf",       int'(bus16.evt_overflow), int'(m_ovf));
    chk("count16",   int'(bus16.transition_count), (m_cnt > 65535) ? 65535 : m_cnt);
    chk("zone_w2",   int'(bus2.zone),          m_zone);
    chk("count2",    int'(bus2.transition_count), (m_cnt > 3) ? 3 : m_cnt);
  endtask

  task automatic cyc(input bit r, input bit v, input bit a, input bit b, input bit rd);
    @(negedge clk);
    rst_n = r; sv = v; f100 = a; f50 = b; rdy = rd;
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  task automatic samples(input int n, input bit a, input bit b, input bit rd);
    for (int i = 0; i < n; i++) cyc(1, 1, a, b, rd);
  endtask

  initial begin
    int tgt;
    bit a, b, v;
    rst_n = 1'b0; sv = 0; f100 = 0; f50 = 0; rdy = 0;
    model_reset();

    // reset state
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    chk("rst_zone", int'(bus16.zone), 3);
    chk("rst_evt",  int'(bus16.evt_valid), 0);

    // first lock-in from UNKNOWN to HIGH
    samples(3, 1, 1, 0);
    chk("pre_commit_zone", int'(bus16.zone), 3);
    samples(1, 1, 1, 0);
    chk("first_zone", int'(bus16.zone), 2);
    chk("first_from", int'(bus16.evt_from), 3);
    chk("first_to",   int'(bus16.evt_to), 2);
    chk("first_cnt",  int'(bus16.transition_count), 0);
    cyc(1, 0, 0, 0, 1);
    chk("pop_evt", int'(bus16.evt_valid), 0);

    // bounce back cancels the pending MID run
    samples(3, 1, 0, 0);
    samples(1, 1, 1, 0);
    samples(3, 1, 0, 0);
    chk("bounce_zone", int'(bus16.zone), 2);
    samples(1, 1, 0, 0);
    chk("mid_zone", int'(bus16.zone), 1);
    chk("mid_from", int'(bus16.evt_from), 2);
    chk("mid_to",   int'(bus16.evt_to), 1);

    // second commit while stalled: held event survives, overflow flags
    samples(4, 0, 0, 0);
    chk("ovf_zone", int'(bus16.zone), 0);
    chk("ovf_from", int'(bus16.evt_from), 2);
    chk("ovf_flag", int'(bus16.evt_overflow), 1);
    chk("ovf_cnt",  int'(bus16.transition_count), 2);
    cyc(1, 0, 0, 0, 1);
    chk("ovf_pop", int'(bus16.evt_valid), 0);

    // back-to-back events with accept on the commit cycle
    cyc(0, 0, 0, 0, 0);
    samples(4, 1, 0, 0);
    samples(3, 1, 1, 0);
    samples(1, 1, 1, 1);
    chk("b2b_valid", int'(bus16.evt_valid), 1);
    chk("b2b_to",    int'(bus16.evt_to), 2);
    chk("b2b_ovf",   int'(bus16.evt_overflow), 0);

    // illegal sample restarts the run; valid gaps do not
    samples(2, 1, 0, 1);
    samples(1, 0, 1, 1);
    chk("illegal_err", int'(bus16.err_illegal), 1);
    for (int i = 0; i < 3; i++) begin
      cyc(1, 1, 1, 0, 1);
      cyc(1, 0, 0, 1, 1);
    end
    chk("restart_zone", int'(bus16.zone), 2);
    samples(1, 1, 0, 1);
    chk("restart_commit", int'(bus16.zone), 1);

    // alternate zones to saturate the narrow counter
    for (int i = 0; i < 3; i++) begin
      samples(4, 1, 1, 1);
      samples(4, 1, 0, 1);
    end
    chk("sat_cnt2", int'(bus2.transition_count), 3);
    cyc(0, 1, 1, 1, 0);
    chk("rst_mid_evt", int'(bus16.evt_valid), 0);
    chk("rst_mid_cnt", int'(bus2.transition_count), 0);

    // randomized traffic with a slowly wandering target zone
    tgt = 1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 11) == 0) tgt = $urandom_range(0, 2);
      v = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 49) == 0) begin
        a = 0; b = 1;
      end else begin
        int z = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 2)) : tgt;
        a = (z != 0); b = (z == 2);
      end
      cyc(($urandom_range(0, 799) != 0), v, a, b, ($urandom_range(0, 2) != 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/negative_threshold_zone_tracker.md
Name: negative_threshold_zone_tracker

Overview:
Sits directly downstream of the dual negative-threshold comparator and consumes its two flags (data_in > -100, data_in > -50). It classifies each valid sample into a zone (LOW <= -100, MID in (-100, -50], HIGH > -50) and debounces zone changes over DEBOUNCE consecutive samples. It emits one from/to event per committed zone change on a valid/ready interface and keeps a saturating transition counter plus sticky error flags for the FIFO/logging stage that follows.

Parameters:
DEBOUNCE, 4, consecutive valid samples of a new zone required to commit it; legal range 1..255
CNT_W, 16, width of the saturating transition counter

Ports:
clk  input  1  single clock, all logic rising-edge
rst_n  input  1  synchronous active-low reset, sampled on rising edge of clk
sample_valid  input  1  flags below are valid this cycle
data_over_neg100  input  1  comparator flag: data_in > -100
data_over_neg50  input  1  comparator flag: data_in > -50
zone  output  2  committed zone: 0=LOW, 1=MID, 2=HIGH, 3=UNKNOWN
evt_valid  output  1  event available
evt_ready  input  1  consumer accepts event when evt_valid && evt_ready
evt_from  output  2  zone before the committed change
evt_to  output  2  zone after the committed change
transition_count  output  CNT_W  committed changes since reset, excluding the first commit from UNKNOWN; saturates at all-ones
err_illegal  output  1  sticky: saw sample_valid with neg50=1, neg100=0
evt_overflow  output  1  sticky: an event was dropped because the output was still occupied

Behaviour:
- Reset (rst_n=0 at a clk edge): zone=UNKNOWN, evt_valid=0, evt_from=evt_to=0, transition_count=0, err_illegal=0, evt_overflow=0, candidate=UNKNOWN, run=0. Reset mid-handshake discards any pending event.
- Sample decode, only when sample_valid=1: {neg100,neg50} = 00 -> LOW, 10 -> MID, 11 -> HIGH, 01 -> illegal.
- sample_valid=0: no state changes except the event handshake.
- Illegal sample: set err_illegal, clear run to 0, set candidate=UNKNOWN. zone is unchanged.
- Legal sample s equal to zone: clear run to 0, set candidate=zone. A bounce back cancels a pending change.
- Legal sample s not equal to zone:
  - If s==candidate, run <= run+1.
  - Otherwise candidate <= s and run <= 1.
  - Commit when the updated run equals DEBOUNCE. With DEBOUNCE=1, the first differing sample commits.
- Commit, registered: on the next clk edge after the DEBOUNCE-th matching sample, zone <= candidate, run <= 0, and an event {from=old zone, to=new zone} is offered. Latency from the qualifying sample to the zone/evt_valid update is 1 cycle.
- transition_count increments on each commit whose old zone != UNKNOWN. It holds at 2^CNT_W-1.
- Event register, one deep:
  - While evt_valid=1 and evt_ready=0, evt_from and evt_to must stay stable.
  - Accept (valid&&ready) with no commit that cycle: evt_valid <= 0.
  - Accept and commit in the same cycle: load the new event, evt_valid stays 1.
  - Commit while evt_valid=1 and evt_ready=0: zone still updates, the new event is dropped, evt_overflow <= 1.
- Sticky flags clear only on reset.
- LOW<->HIGH jumps are legal and produce a single event, e.g. from=0, to=2.

Decomposition:
- Package negative_threshold_pkg holds:
  - zone typedef (2-bit)
  - constants ZONE_LOW=0, ZONE_MID=1, ZONE_HIGH=2, ZONE_UNKNOWN=3
  - a decode function flags->zone with an illegal indication
- One natural sub-module: zone_event_reg, the one-deep valid/ready event holding register with overflow detection. Debounce FSM and counter stay in the top.

Test Plan:
- Reset, then 4 valid samples of {1,1} with DEBOUNCE=4 -> one cycle after the 4th sample: zone=2, evt_valid=1, from=3, to=2, transition_count=0.
- From HIGH: 3x{1,0}, 1x{1,1}, 4x{1,0} -> no commit after the first 3; MID commits only after the final 4, event from=2, to=1, count=1.
- Hold evt_ready=0 and force two commits (HIGH->MID->LOW) -> first event held unchanged (2->1), zone=0, evt_overflow=1, count=2; raise ready -> evt_valid drops next cycle.
- evt_ready=1 in the same cycle a new commit lands -> back-to-back events with evt_valid continuously 1, no overflow.
- Inject {0,1} with sample_valid=1 midway through a debounce run -> err_illegal=1, run restarts (needs 4 fresh samples); sample_valid=0 gaps between samples do not break the run.
- CNT_W=2, 5 alternating committed changes after the first -> transition_count saturates at 3; assert rst_n=0 while evt_valid=1 -> all outputs return to reset values on the next edge.
